conf_int_mac_acc_stage: RTL and testbench

Downstream accumulate stage for the approximate/accurate 32-bit multiplier wrapper. It consumes the wrapper's 64-bit product output, one product per handshake, and sums a programmed-length vector of products into a wide saturating accumulator. It reports the dot-product result through a valid/ready output port. It also counts how many of the accumulated products came from the approximate path, so precision-sweep experiments can log result quality per vector.

---
 rtl/conf_int_mac_acc_stage.sv | 120 ++++++++++++
 tb/tb_conf_int_mac_acc_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_mac_acc_stage.sv
// Accumulate stage behind the approximate/accurate multiplier wrapper.
// It sums a programmed-length vector of unsigned products with saturation, counts approximate products, and hands the result off over valid/ready.
module conf_int_mac_acc_stage #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_BITWIDTH       = 72,
  parameter int LEN_BITWIDTH       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_BITWIDTH-1:0] vec_len,
  input  logic                    abort,
  input  logic [63:0]             prod,
  input  logic                    prod_apx,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  output logic [ACC_BITWIDTH-1:0] acc_out,
  output logic [LEN_BITWIDTH-1:0] apx_cnt,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  // state | meaning
  // IDLE  | waiting for start; result of the previous vector still visible
  // ACCUM | accepting products until len have been summed
  // DONE  | result presented with out_valid until out_ready
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  if (ACC_BITWIDTH < 64 || DATA_PATH_BITWIDTH < 1) begin : g_bad_param
    $error("conf_int_mac_acc_stage: ACC_BITWIDTH must be >= 64");
  end

  state_t                  state, state_nxt;
  logic [ACC_BITWIDTH-1:0] acc, acc_nxt;
  logic [LEN_BITWIDTH-1:0] cnt, cnt_nxt;
  logic [LEN_BITWIDTH-1:0] len, len_nxt;
  logic [LEN_BITWIDTH-1:0] apx, apx_nxt;
  logic                    ovf_q, ovf_nxt;
  logic [ACC_BITWIDTH:0]   sum;
  logic                    accept;

  // One spare bit catches the carry; once saturated, any further nonzero add
  // carries again, so acc stays pinned at all-ones without extra state.
  assign sum    = {1'b0, acc} + {{(ACC_BITWIDTH + 1 - 64){1'b0}}, prod};
  assign accept = (state == ACCUM) && prod_valid;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len;
    apx_nxt   = apx;
    ovf_nxt   = ovf_q;
    if (abort) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      apx_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_nxt   = vec_len;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            apx_nxt   = '0;
            ovf_nxt   = 1'b0;
            state_nxt = (vec_len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sum[ACC_BITWIDTH]) begin
              acc_nxt = '1;
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt = sum[ACC_BITWIDTH-1:0];
            end
            cnt_nxt = cnt + 1'b1;
            if (prod_apx) apx_nxt = apx + 1'b1;
            if (cnt == len - 1'b1) state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      apx   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      apx   <= apx_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign prod_ready = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign apx_cnt    = apx;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_conf_int_mac_acc_stage.sv
// Randomized bench for conf_int_mac_acc_stage with a vector-level reference model.
// A 64-bit accumulator is used so saturation is reachable with single products.
module tb_conf_int_mac_acc_stage;
  localparam int ACC_W = 64;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             abort = 1'b0;
  logic [63:0]      prod = '0;
  logic             prod_apx = 1'b0;
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic [LEN_W-1:0] apx_cnt;
  logic             ovf;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] vec_p[$];
  bit          vec_a[$];

  conf_int_mac_acc_stage #(
    .DATA_PATH_BITWIDTH(16),
    .ACC_BITWIDTH(ACC_W),
    .LEN_BITWIDTH(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .abort(abort),
    .prod(prod), .prod_apx(prod_apx), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .apx_cnt(apx_cnt), .ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-vector reference: exact wide sum, clamped once at the end. Because
  // every product is unsigned, the running sum overflows iff the total does.
  task automatic ref_vec(output logic [ACC_W-1:0] e_acc, output int e_apx, output bit e_ovf);
    logic [127:0] total = '0;
    logic [127:0] lim;
    lim   = (128'd1 << ACC_W) - 128'd1;
    e_apx = 0;
    foreach (vec_p[i]) begin
      total += {64'd0, vec_p[i]};
      if (vec_a[i]) e_apx++;
    end
    e_ovf = (total > lim);
    e_acc = e_ovf ? lim[ACC_W-1:0] : total[ACC_W-1:0];
  endtask

  task automatic push(input logic [63:0] p, input bit a);
    vec_p.push_back(p);
    vec_a.push_back(a);
  endtask

  // Drives the queued vector with random input gaps, then holds the result
  // under back-pressure for bp cycles before releasing it.
  task automatic run_vector(input int bp, input int gap_max);
    logic [ACC_W-1:0] e_acc;
    int               e_apx;
    bit               e_ovf;
    int               len;
    len = vec_p.size();
    ref_vec(e_acc, e_apx, e_ovf);
    @(negedge clk);
    start   = 1'b1;
    vec_len = len[LEN_W-1:0];
    chk("idle_busy", busy, 0);
    chk("idle_prod_ready", prod_ready, 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk("accum_prod_ready", prod_ready, 1);
      chk("accum_out_valid", out_valid, 0);
      repeat ($urandom_range(0, gap_max)) begin
        prod_valid = 1'b0;
        prod       = {$urandom, $urandom};
        prod_apx   = 1'($urandom);
        @(negedge clk);
        chk("gap_prod_ready", prod_ready, 1);
      end
      prod_valid = 1'b1;
      prod       = vec_p[i];
      prod_apx   = vec_a[i];
      @(negedge clk);
      prod_valid = 1'b0;
    end
    for (int k = 0; k <= bp; k++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_busy", busy, 1);
      chk("done_prod_ready", prod_ready, 0);
      chk("done_acc_out", acc_out, e_acc);
      chk("done_apx_cnt", apx_cnt, e_apx);
      chk("done_ovf", ovf, e_ovf);
      if (k == bp) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_busy", busy, 0);
    chk("release_acc_hold", acc_out, e_acc);
    vec_p.delete();
    vec_a.delete();
  endtask

  initial begin
    #1;
    chk("rst_acc_out", acc_out, 0);
    chk("rst_apx_cnt", apx_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    push(3, 0); push(5, 0); push(7, 0); push(9, 0);
    run_vector(0, 0);

    push(64'h1_0000_0000, 0); push(2, 0); push(64'h10, 0);
    run_vector(5, 3);

    push(64'hFFFF_0000, 1); push(64'hFFFF_0000, 0); push(64'hFFFF_0000, 1);
    push(64'hFFFF_0000, 1); push(64'hFFFF_0000, 0);
    run_vector(1, 1);

    push(64'hFFFF_FFFF_FFFF_FFFF, 0); push(1, 1);
    run_vector(0, 0);

    run_vector(2, 0);

    // Abort after two saturating accepts; the product presented with abort must be dropped.
    @(negedge clk);
    start   = 1'b1;
    vec_len = 8'd4;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 64'hFFFF_FFFF_FFFF_FFFF;
    prod_apx   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_ovf", ovf, 1);
    prod  = 64'd30;
    abort = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    prod_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_acc_out", acc_out, 0);
    chk("abort_apx_cnt", apx_cnt, 0);
    chk("abort_ovf", ovf, 0);
    repeat (3) begin
      chk("abort_out_valid", out_valid, 0);
      @(negedge clk);
    end
    push(7, 0);
    run_vector(0, 0);

    // start together with out_ready in DONE only releases the result.
    @(negedge clk);
    start   = 1'b1;
    vec_len = 8'd1;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 64'd9;
    prod_apx   = 1'b0;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("done_start_pre", out_valid, 1);
    start     = 1'b1;
    vec_len   = 8'd2;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    chk("done_start_busy", busy, 0);
    chk("done_start_acc", acc_out, 9);
    @(negedge clk);
    chk("done_start_ignored", busy, 0);

    for (int v = 0; v < 30; v++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 2))
          0:       push(64'($urandom_range(0, 1000)), 1'($urandom));
          1:       push({32'd0, $urandom}, 1'($urandom));
          default: push({$urandom, $urandom}, 1'($urandom));
        endcase
      end
      run_vector($urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a vector.
    @(negedge clk);
    start   = 1'b1;
    vec_len = 8'd3;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 64'd5;
    prod_apx   = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("pre_rst_acc", acc_out, 5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_acc_out", acc_out, 0);
    chk("async_rst_apx_cnt", apx_cnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_prod_ready", prod_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
